// File: rtl/spi_fram_model.sv
// Cycle-accurate SPI (mode 0) FRAM slave model. It has a write-enable latch, status-register
// block protection, RDID, and address wrap at DEPTH. Preload contents through `memory`.
module spi_fram_model #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          ADDR_BYTES = 2,
  parameter logic [31:0] DEVICE_ID  = 32'h04_7F_03_02,
  parameter int          SCK_SYNC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       spi_sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wel,
  output logic [1:0] bp
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  // Synchroniser idle value, packed as {sck, cs, mosi}: clock low, chip deselected.
  localparam logic [2:0] SYNC_IDLE = 3'b010;

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, READ, WRITE, STAT_R, STAT_W, ID, IGNORE
  } state_t;

  logic [7:0] memory [DEPTH];

  logic [2:0]            sync_q [SCK_SYNC];
  logic                  sck_s, cs_s, mosi_s;
  logic                  sck_prev, cs_prev;
  logic                  sck_rise, sck_fall, cs_rise, cs_fall;

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [6:0]            shift_q;
  logic [7:0]            byte_next;
  logic                  byte_done;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next, addr_inc;
  logic [1:0]            addr_cnt;
  logic [7:0]            out_sr;
  logic [1:0]            id_idx;
  logic                  rd_cmd, write_cmd;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [7:0]            status;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return DEVICE_ID[31:24];
      2'd1:    return DEVICE_ID[23:16];
      2'd2:    return DEVICE_ID[15:8];
      default: return DEVICE_ID[7:0];
    endcase
  endfunction

  function automatic logic is_protected(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] b);
    case (b)
      2'b00:   return 1'b0;
      2'b01:   return &a[ADDR_WIDTH-1 -: 2];
      2'b10:   return a[ADDR_WIDTH-1];
      default: return 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SCK_SYNC; i++) sync_q[i] <= SYNC_IDLE;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sync_q[0] <= {spi_sck, cs, mosi};
      for (int i = 1; i < SCK_SYNC; i++) sync_q[i] <= sync_q[i-1];
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign {sck_s, cs_s, mosi_s} = sync_q[SCK_SYNC-1];

  // A chip-select rise gates off the SCK edges, so deselect always wins over a coincident edge.
  assign sck_rise  = !cs_s &&  sck_s && !sck_prev;
  assign sck_fall  = !cs_s && !sck_s &&  sck_prev;
  assign cs_rise   =  cs_s && !cs_prev;
  assign cs_fall   = !cs_s &&  cs_prev;

  assign byte_next = {shift_q, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign addr_next = ADDR_WIDTH'({addr_q, byte_next});
  assign addr_inc  = addr_q + ADDR_WIDTH'(1);
  assign status    = {4'b0000, bp, wel, 1'b0};

  // NOTE: every state update uses <=, so all branches see start-of-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      addr_cnt  <= '0;
      out_sr    <= '0;
      id_idx    <= '0;
      rd_cmd    <= 1'b0;
      write_cmd <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wel       <= 1'b0;
      bp        <= 2'b00;
    end else begin
      wr_pend <= 1'b0;
      if (cs_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        write_cmd <= 1'b0;
        if (write_cmd) wel <= 1'b0;
      end else if (cs_fall) begin
        state     <= CMD;
        bit_cnt   <= '0;
        rd_cmd    <= 1'b0;
        write_cmd <= 1'b0;
      end else begin
        if (sck_rise) begin
          shift_q <= byte_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              case (byte_next)
                OP_WREN: begin wel <= 1'b1; state <= IGNORE; end
                OP_WRDI: begin wel <= 1'b0; state <= IGNORE; end
                OP_RDSR: begin out_sr <= status; state <= STAT_R; end
                OP_WRSR: begin write_cmd <= 1'b1; state <= STAT_W; end
                OP_READ, OP_WRITE: begin
                  rd_cmd    <= (byte_next == OP_READ);
                  write_cmd <= (byte_next == OP_WRITE);
                  addr_q    <= '0;
                  addr_cnt  <= '0;
                  state     <= ADDR;
                end
                OP_RDID: begin
                  out_sr <= id_byte(2'd0);
                  id_idx <= 2'd1;
                  state  <= ID;
                end
                default: state <= IGNORE;
              endcase
            end
            ADDR: begin
              addr_q   <= addr_next;
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == ADDR_LAST) begin
                if (rd_cmd) begin
                  out_sr <= memory[addr_next];
                  state  <= READ;
                end else begin
                  state  <= WRITE;
                end
              end
            end
            READ: begin
              addr_q <= addr_inc;
              out_sr <= memory[addr_inc];
            end
            WRITE: begin
              // Dropped writes still advance the address.
              if (wel && !is_protected(addr_q, bp)) begin
                wr_pend <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= byte_next;
              end
              addr_q <= addr_inc;
            end
            STAT_R: out_sr <= status;
            STAT_W: begin
              if (wel) bp <= byte_next[3:2];
              state <= IGNORE;
            end
            ID: begin
              out_sr <= id_byte(id_idx);
              id_idx <= id_idx + 2'd1;
            end
            default: ;
          endcase
        end
        if (sck_fall) begin
          if (state inside {READ, STAT_R, ID}) begin
            miso    <= out_sr[7];
            out_sr  <= {out_sr[6:0], 1'b0};
            miso_oe <= 1'b1;
          end else begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
        end
      end
    end
  end

  // NOTE: memory has no reset, so its contents survive rst and can be preloaded hierarchically.
  always_ff @(posedge clk) begin
    if (wr_pend) memory[wr_addr] <= wr_data;
  end
endmodule

// File: doc/spi_fram_model.md
Name: spi_fram_model

Overview:
- Parametrised, cycle-accurate SPI FRAM slave model; the successor to the fixed 8 KiB FRAM model used by the top-level bench.
- Generalised in depth, address byte count and device ID.
- Adds status-register block protection, write-enable latch semantics, RDID, and address wrap at DEPTH.
- Sits in the bench next to the user project, on the SPI pins. Memory is preloadable via hierarchical $readmemh into array `memory`.

Parameters:
ADDR_WIDTH, 13, significant address bits; DEPTH = 2**ADDR_WIDTH bytes
ADDR_BYTES, 2, address bytes sent after READ/WRITE opcodes (1..3)
DEVICE_ID, 32'h04_7F_03_02, RDID response, MSB byte first
SCK_SYNC, 2, synchroniser stages on spi_sck/cs/mosi (>=1)

Ports:
clk      input   1  system clock; all state on rising edge
rst      input   1  asynchronous, active-high reset
cs       input   1  chip select, active-low
spi_sck  input   1  SPI clock, mode 0
mosi     input   1  serial data in, MSB first
miso     output  1  serial data out, MSB first; 0 when deselected
miso_oe  output  1  1 while a read phase drives miso
wel      output  1  write-enable latch (status bit 1)
bp       output  2  block-protect bits (status bits 3:2)

Behaviour:
- Reset: miso=0, miso_oe=0, wel=0, bp=0, FSM=IDLE, bit counter=0. Memory contents are not cleared.
- Inputs pass through SCK_SYNC flops. Edges are detected against the previous synchronised value. Required SCK half-period >= SCK_SYNC+2 clk.
- SCK rising edge (cs low): shift mosi into an 8-bit register; bit counter increments; byte completes on the 8th rise.
- SCK falling edge: miso updates to the next output bit in the clk after detection.
- FSM states: IDLE, CMD, ADDR, READ, WRITE, STAT_R, STAT_W, ID, IGNORE.
- cs falling -> CMD, bit counter=0.
- cs rising in any state -> IDLE. miso=0, miso_oe=0. A partial byte is discarded.
- After a cs rising edge that ends a WRITE or WRSR command, wel=0.
- Opcodes decoded at the CMD byte:
  - 06 WREN: wel=1. State -> IGNORE.
  - 04 WRDI: wel=0. State -> IGNORE.
  - 05 RDSR: state -> STAT_R. Output {4'b0,bp,wel,1'b0} repeatedly until cs high.
  - 01 WRSR: state -> STAT_W. On the next full byte, bp=byte[3:2] only if wel=1; remaining bytes ignored.
  - 03 READ / 02 WRITE: state -> ADDR.
  - 9F RDID: state -> ID. Output the 4 ID bytes, then repeat them.
  - Any other opcode: state -> IGNORE, no effect.
- ADDR: collect ADDR_BYTES bytes MSB first; addr = collected value masked to ADDR_WIDTH (upper bits ignored).
- READ: first data bit is driven after the SCK fall following the last address bit; miso_oe=1. After each byte, addr = (addr+1) mod DEPTH (DEPTH-1 wraps to 0).
- WRITE: on each completed byte, memory[addr] is written in the clk after the byte completes, only if wel=1 and addr is not protected. addr then increments with the same wrap. A write to a protected or wel=0 address is silently dropped, but addr still increments.
- Protection by bp: 00 none; 01 upper quarter (addr >= 3*DEPTH/4); 10 upper half; 11 all.
- Simultaneous cs rise and SCK edge: cs wins, edge ignored.
- rst mid-transfer: immediate IDLE and outputs to reset values. Any byte not yet committed is lost.

Test Plan:
- Preload memory[0x0010]=A5, [0x0011]=3C. cs low, send 03 00 10, clock 16 bits -> miso bytes A5,3C; miso_oe=1 during data; miso=0 after cs high.
- Send 06, then 02 1F FF 11 22 -> memory[0x1FFF]=11, memory[0x0000]=22 (wrap). After cs high, RDSR returns 00 (wel cleared).
- Send 02 00 20 55 without a prior WREN -> memory[0x0020] unchanged; RDSR returns 00.
- Send WREN, WRSR 08 (bp=10), WREN, WRITE 10 00 77 -> memory[0x1000] unchanged (protected). Then WREN, WRITE 00 40 77 -> memory[0x0040]=77. RDSR returns 08.
- RDID clocked for 40 bits -> 04 7F 03 02 04. Opcode AB -> no miso activity, no state change.
- Assert rst midway through the 2nd data byte of a WRITE with wel=1 -> 1st byte committed, 2nd not. wel=0, bp=0, miso=0 immediately.
